// File: rtl/pump_controller.sv
// Tank fill-pump sequencer: dwell-time limited pump control with fill timeout,
// sensor-error persistence and latched faults cleared by operator acknowledge.
module pump_controller #(
  parameter int unsigned MIN_ON_MS      = 5000,
  parameter int unsigned MIN_OFF_MS     = 2000,
  parameter int unsigned MAX_FILL_MS    = 60000,
  parameter int unsigned ERR_PERSIST_MS = 50
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clk_1kHz,
  input  logic       GOET,
  input  logic       LOET,
  input  logic       input_error,
  input  logic       ack_button,
  output logic       pump_on,
  output logic       alarm,
  output logic [1:0] fault_code,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON_MS);
  localparam logic [CNT_W-1:0] MIN_OFF_C = CNT_W'(MIN_OFF_MS);
  localparam logic [CNT_W-1:0] MAX_FILL_C = CNT_W'(MAX_FILL_MS);
  localparam logic [CNT_W-1:0] ERR_C     = CNT_W'(ERR_PERSIST_MS);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_SENSOR   = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;
  localparam logic [1:0] FC_CONFLICT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILLING = 2'b01,
    ST_FAULT   = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             k_q, k_d;
  logic             tick_q, tick_d;
  logic             ack_prev_q, ack_prev_d;
  logic             ack_pending_q, ack_pending_d;
  logic             pump_on_q, pump_on_d;
  logic             alarm_q, alarm_d;

  logic [CNT_W-1:0] elapsed_inc;
  logic [CNT_W-1:0] err_inc;
  logic             ack_seen;
  logic             conflict;
  logic             fault_hit;
  logic [1:0]       fault_sel;

  // Next-state, counters and registered output decode
  always_comb begin
    k_d           = clk_1kHz;
    tick_d        = clk_1kHz & ~k_q;
    ack_prev_d    = ack_button;
    ack_seen      = ack_pending_q | (ack_button & ~ack_prev_q);
    conflict      = GOET & LOET;
    elapsed_inc   = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + CNT_W'(1);
    err_inc       = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);

    state_d       = state_q;
    fault_code_d  = fault_code_q;
    elapsed_d     = elapsed_q;
    err_cnt_d     = err_cnt_q;
    ack_pending_d = ack_seen;
    fault_hit     = 1'b0;
    fault_sel     = FC_NONE;

    // Fault priority: sensor error, then threshold conflict, then fill timeout
    if (input_error && (err_inc >= ERR_C)) begin
      fault_hit = 1'b1;
      fault_sel = FC_SENSOR;
    end else if (conflict) begin
      fault_hit = 1'b1;
      fault_sel = FC_CONFLICT;
    end else if ((state_q == ST_FILLING) && (elapsed_inc >= MAX_FILL_C) && !GOET) begin
      fault_hit = 1'b1;
      fault_sel = FC_TIMEOUT;
    end

    if (tick_q) begin
      elapsed_d     = elapsed_inc;
      err_cnt_d     = input_error ? err_inc : '0;
      ack_pending_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (fault_hit) begin
            state_d      = ST_FAULT;
            fault_code_d = fault_sel;
          end else if (LOET && !GOET && (elapsed_inc >= MIN_OFF_C)) begin
            state_d = ST_FILLING;
          end
        end
        ST_FILLING: begin
          if (fault_hit) begin
            state_d      = ST_FAULT;
            fault_code_d = fault_sel;
          end else if (GOET && !LOET && (elapsed_inc >= MIN_ON_C)) begin
            state_d = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (ack_seen && !input_error && !conflict) begin
            state_d      = ST_IDLE;
            fault_code_d = FC_NONE;
          end
        end
        default: begin
          state_d      = ST_IDLE;
          fault_code_d = FC_NONE;
        end
      endcase
      if (state_d != state_q) begin
        elapsed_d = '0;
      end
    end

    pump_on_d = (state_d == ST_FILLING);
    alarm_d   = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fault_code_q  <= FC_NONE;
      elapsed_q     <= '0;
      err_cnt_q     <= '0;
      k_q           <= 1'b0;
      tick_q        <= 1'b0;
      ack_prev_q    <= 1'b0;
      ack_pending_q <= 1'b0;
      pump_on_q     <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fault_code_q  <= fault_code_d;
      elapsed_q     <= elapsed_d;
      err_cnt_q     <= err_cnt_d;
      k_q           <= k_d;
      tick_q        <= tick_d;
      ack_prev_q    <= ack_prev_d;
      ack_pending_q <= ack_pending_d;
      pump_on_q     <= pump_on_d;
      alarm_q       <= alarm_d;
    end
  end

  assign pump_on    = pump_on_q;
  assign alarm      = alarm_q;
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule

// File: doc/pump_controller.md
# pump_controller

Tank fill-pump sequencer that sits directly downstream of threshold_comparator. It consumes the level flags GOET/LOET, the sensor input_error flag, and the 1 kHz timebase. It drives the pump relay and an alarm output. Minimum on/off dwell times, a fill timeout and fault latching with operator acknowledge keep a noisy or broken sensor chain from chattering the pump or dry-running it.

## Interface
- MIN_ON_MS, 5000: minimum pump-on time in ms before GOET may stop it.
- MIN_OFF_MS, 2000: minimum pump-off time in ms before LOET may start it.
- MAX_FILL_MS, 60000: fill timeout in ms; must be greater than MIN_ON_MS.
- ERR_PERSIST_MS, 50: consecutive ms of input_error before faulting.
- All parameters are in 1..65535.
- clk_100MHz  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- clk_1kHz  in  1  1 kHz square wave from clock_manager, sampled as data; never used as a clock.
- GOET  in  1  level greater than or equal to high threshold.
- LOET  in  1  level less than or equal to low threshold.
- input_error  in  1  invalid sensor pattern.
- ack_button  in  1  debounced acknowledge level.
- pump_on  out  1  pump relay drive.
- alarm  out  1  buzzer/LED alarm.
- fault_code  out  2  00 none, 01 sensor error, 10 fill timeout, 11 threshold conflict (GOET and LOET both high).
- state  out  2  00 IDLE, 01 FILLING, 10 FAULT.

## Operation
- Tick: one-cycle pulse on the cycle after clk_1kHz is first sampled high (registered edge detect). All inputs except ack_button are evaluated only on tick cycles.
- elapsed: 16-bit counter, saturating at 65535. It is cleared on every state change. Each tick evaluates conditions with elapsed already incremented, so the nth tick after entry sees n.
- err_cnt: 16-bit saturating counter.
  - On a tick with input_error=1 it increments.
  - On a tick with input_error=0 it clears.
  - A fault is raised when the incremented value reaches ERR_PERSIST_MS.
- ack: a rising edge of ack_button, detected on any cycle, sets ack_pending. Every tick clears ack_pending after evaluation, so a stale ack never carries into a later tick.
- Fault priority, evaluated on each tick in IDLE or FILLING:
  - err_cnt condition gives FAULT with code 01.
  - Otherwise GOET and LOET both high gives FAULT with code 11.
  - Otherwise, in FILLING only, elapsed equal to or greater than MAX_FILL_MS with GOET=0 gives FAULT with code 10.
- IDLE (pump off): go to FILLING on a tick with LOET=1, GOET=0 and elapsed equal to or greater than MIN_OFF_MS.
- FILLING (pump on): go to IDLE on a tick with GOET=1, LOET=0 and elapsed equal to or greater than MIN_ON_MS. GOET before MIN_ON_MS is ignored; the pump stays on.
- FAULT (pump off, alarm on): fault_code holds its value.
  - Exit to IDLE on a tick with ack_pending=1, input_error=0, and not (GOET and LOET).
  - On exit, fault_code becomes 00 and elapsed clears, so MIN_OFF_MS applies again.
  - While in FAULT, err_cnt keeps running but its result is ignored.
- Outputs are Moore-decoded from registered state and fault_code.
  - pump_on = (state == FILLING).
  - alarm = (state == FAULT).

## Timing
- Reset values: state=IDLE, pump_on=0, alarm=0, fault_code=00. elapsed, err_cnt and ack_pending are 0. The tick edge-detect register is 0.
- Reset applied mid-fill or in FAULT: outputs return to their reset values on the clock edge after reset is sampled high. The fault is not retained.
- After reset, the first fill needs MIN_OFF_MS ticks.
- Latency: state, pump_on and alarm update on the clock edge that ends the tick cycle. They are visible 1 cycle after the tick pulse, which is 2 cycles after clk_1kHz first samples high.
- ack_button edge and a tick in the same cycle: the edge is honoured on that tick.
- An ack arriving between ticks is honoured on the next tick only.
- elapsed saturation: at 65535, comparisons still hold because MAX_FILL_MS is at most 65535.

## Test plan
Parameters for all scenarios: MIN_ON_MS=5, MIN_OFF_MS=3, MAX_FILL_MS=20, ERR_PERSIST_MS=2.
1. Reset release with LOET=1 held -> pump_on rises 1 cycle after the 3rd tick. Then GOET=1, LOET=0 at tick 2 in FILLING -> pump stays on, and pump_on falls 1 cycle after the 5th FILLING tick.
2. In FILLING, GOET held 0 -> on the 20th tick state=FAULT, fault_code=10, pump_on=0, alarm=1. An ack pulse between ticks -> IDLE on the next tick, fault_code=00.
3. input_error high for 1 tick, low for 1, then high for 2 -> fault only on the 2nd consecutive high tick, fault_code=01. Ack while input_error is still 1 -> remains in FAULT, and ack_pending is cleared on that tick.
4. GOET=LOET=1 in IDLE -> FAULT with code 11 on the next tick. If input_error has also reached persistence on the same tick -> code 01 wins.
5. Reset asserted for 1 cycle mid-FILLING and mid-FAULT -> pump_on=0, alarm=0, state=00, fault_code=00 next cycle. A subsequent fill needs 3 ticks.
6. clk_1kHz held static -> no state change for 10000 cycles regardless of inputs. A single ack_button edge with no tick -> no effect until the tick occurs.
